join4: RTL
==========

# join4

Clocked four-way join: the fan-in counterpart to the PE's four-way copy. Each of four input channels delivers one WIDTH-bit packet into its own holding slot. Once all four slots are full, the block emits a single concatenated 4*WIDTH-bit packet on R. It then reopens all four slots. It sits at the PE's collection points where four partial results (filter/ifmap/psum lanes) must be gathered into one packet before forwarding.

## Interface
- WIDTH, 4, bits per input packet.
- CNT_W, 16, width of the joined-packet counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- L0_data..L3_data  input  WIDTH each  input packets.
- L0_valid..L3_valid  input  1 each  sender presents data.
- L0_ready..L3_ready  output  1 each  slot k empty; transfer on edge where valid_k && ready_k.
- R_data  output  4*WIDTH  joined packet {L3,L2,L1,L0} (L0 in bits WIDTH-1:0).
- R_valid  output  1  output register holds a packet.
- R_ready  input  1  receiver accepts; transfer on edge where R_valid && R_ready.
- join_count  output  CNT_W  number of packets loaded into the output register since reset; wraps modulo 2^CNT_W.

## Operation
- Per-lane state: full_k (EMPTY/FULL) and slot_k[WIDTH-1:0].
- Lk_ready = !full_k. This is a registered-only path with no combinational dependency on valid or R_ready.
- EMPTY->FULL on an edge with Lk_valid && Lk_ready: slot_k <= Lk_data.
- Lanes fill independently and in any order. A full lane holds its data and deasserts ready, so a sender on that lane stalls.
- all_full = &full_k.
- out_free = !R_valid || R_ready.
- fire = all_full && out_free.
- On a fire edge:
  - R_data <= {slot_3, slot_2, slot_1, slot_0}.
  - R_valid <= 1.
  - All full_k <= 0.
  - join_count <= join_count + 1, wrapping from 2^CNT_W-1 to 0.
- On an edge with R_valid && R_ready and no fire: R_valid <= 0. R_data holds its old value.
- Simultaneous drain and fire: the new packet replaces the old one, and R_valid stays 1 with no bubble.
- Back-pressure: if R_valid && !R_ready and all_full, nothing moves. Slots hold, and all Lk_ready stay low.
- R_data is stable while R_valid && !R_ready.
- No packet is ever dropped or duplicated.

## Timing
- Reset values (asynchronous on rst rise, held while rst=1):
  - full_k=0, so all Lk_ready=1.
  - slot_k=0.
  - R_valid=0.
  - R_data=0.
  - join_count=0.
- Reset mid-operation discards partial slot contents and any pending output packet.
- Latency: if the last missing lane is captured at edge N and out_free holds at edge N+1, R_valid=1 after edge N+1 (one cycle).
- Slots reopen after the fire edge, so the earliest next capture is edge N+2. Peak throughput is one joined packet per 2 cycles.
- Handshake rules:
  - Senders must hold Lk_data and Lk_valid until accepted.
  - The block holds R_valid and R_data until accepted.
  - Valid never depends combinationally on ready, in either direction.

## Test plan
- Reset behaviour. Assert rst mid-cycle with lanes 0 and 2 full and R_valid=1. Required response: all outputs go to their reset values immediately. After release, L0_ready..L3_ready=1, R_valid=0, join_count=0.
- Basic join, WIDTH=4, R_ready=1. Present L0..L3 = 1,2,3,4 simultaneously at edge 1. Required response: R_valid=1 after edge 2, R_data=16'h4321, join_count=1. Lk_ready=0 during cycle 2 and back to 1 after edge 2.
- Staggered arrival. Send L2=A at edge 1, L0=5 at edge 3, L3=F at edge 4, L1=0 at edge 7. Required response: lane 2 ready stays 0 from edge 1 until the fire at edge 8. R_data=16'hFA05 after edge 8.
- Back-pressure, R_ready=0. Complete two joins, {4,3,2,1} then {8,7,6,5}. Required response: the first packet holds on R_data, the second set remains in the slots, and all Lk_ready=0. Raise R_ready for one cycle: R_data changes to 16'h8765 with no R_valid gap.
- Throughput, all valids and R_ready held high. Required response: one R packet every 2 cycles, with join_count incrementing each time.
- Counter wrap, CNT_W=4. Run 17 joins. Required response: join_count reads 15, then 0, then 1.

Source files
------------

// File: rtl/join4.sv
`default_nettype none
// ============================================================================
// Module   : join4
// Purpose  : Four-way clocked join. Gathers one packet per input lane and
//            emits them concatenated {L3,L2,L1,L0} through a single output register.
// Revision : 1.0 - initial release
// ============================================================================
module join4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   L0_data,
    input  logic [WIDTH-1:0]   L1_data,
    input  logic [WIDTH-1:0]   L2_data,
    input  logic [WIDTH-1:0]   L3_data,
    input  logic               L0_valid,
    input  logic               L1_valid,
    input  logic               L2_valid,
    input  logic               L3_valid,
    output logic               L0_ready,
    output logic               L1_ready,
    output logic               L2_ready,
    output logic               L3_ready,
    output logic [4*WIDTH-1:0] R_data,
    output logic               R_valid,
    input  logic               R_ready,
    output logic [CNT_W-1:0]   join_count
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t        r_state     [4];
    lane_state_t        w_state_nxt [4];
    logic [WIDTH-1:0]   r_slot      [4];
    logic [WIDTH-1:0]   w_in_data   [4];
    logic [3:0]         w_in_valid;
    logic [3:0]         w_full;
    logic [3:0]         w_capture;
    logic               w_all_full;
    logic               w_out_free;
    logic               w_fire;

    logic [4*WIDTH-1:0] r_rdata;
    logic               r_rvalid;
    logic [CNT_W-1:0]   r_count;

    assign w_in_data[0] = L0_data;
    assign w_in_data[1] = L1_data;
    assign w_in_data[2] = L2_data;
    assign w_in_data[3] = L3_data;
    assign w_in_valid   = {L3_valid, L2_valid, L1_valid, L0_valid};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_full[k]    = (r_state[k] == FULL);
            w_capture[k] = w_in_valid[k] && (r_state[k] == EMPTY);
        end
    end

    assign w_all_full = &w_full;
    assign w_out_free = !r_rvalid || R_ready;
    assign w_fire     = w_all_full && w_out_free;

    // A firing edge only happens with every lane full, so capture and
    // reopen never coincide on the same lane.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_state_nxt[k] = r_state[k];
            if (w_fire)
                w_state_nxt[k] = EMPTY;
            else if (w_capture[k])
                w_state_nxt[k] = FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= EMPTY;
                r_slot[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= w_state_nxt[k];
                if (w_capture[k])
                    r_slot[k] <= w_in_data[k];
            end
        end
    end

    // Fire takes priority over drain so a simultaneous accept leaves no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_count  <= '0;
        end else if (w_fire) begin
            r_rdata  <= {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
            r_rvalid <= 1'b1;
            r_count  <= r_count + 1'b1;
        end else if (r_rvalid && R_ready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign L0_ready   = !w_full[0];
    assign L1_ready   = !w_full[1];
    assign L2_ready   = !w_full[2];
    assign L3_ready   = !w_full[3];
    assign R_data     = r_rdata;
    assign R_valid    = r_rvalid;
    assign join_count = r_count;

endmodule
`default_nettype wire
